// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg -- shared receiver state encodings and counter sizing helper.
// Rev 1.0
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_param_if.sv
`default_nettype none
// uart_rx_param_if -- receiver output bundle with valid/ready handshake.
// Rev 1.0; adds parity_err when UART_RX_PARITY_EN is defined.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;

  modport master (output data, valid, frame_err, overrun, busy, parity_err, input ready);
  modport slave  (input data, valid, frame_err, overrun, busy, parity_err, output ready);
`else
  modport master (output data, valid, frame_err, overrun, busy, input ready);
  modport slave  (input data, valid, frame_err, overrun, busy, output ready);
`endif
endinterface
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// uart_sync2 -- two-flop synchroniser with parametrised reset value.
// Rev 1.0
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// uart_rx_param -- oversampling UART receiver, mid-bit sampling, valid/ready output with
// framing/overrun flags. Rev 1.0; optional parity check with UART_RX_PARITY_EN.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  uart_rx_param_if.master bus
);
  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int BW = cnt_width(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_rx_param: unsupported parameter set");
  end

  uart_state_e          state, next_state;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 armed;
  logic                 done;
  logic                 stop_bit;
  logic                 busy_c, half_tick, full_tick, cnt_clr;
  logic                 data_smp, stop_smp;
  logic [DATA_BITS-1:0] data_r;
  logic                 valid_r, frame_err_r, overrun_r;
  logic                 accept, load, drop;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (armed && !rx_s) next_state = START;
      START:  if (half_tick) next_state = rx_s ? IDLE : DATA;
      DATA:   if (full_tick && bit_idx == LAST_BIT)
`ifdef UART_RX_PARITY_EN
                next_state = PARITY;
      PARITY: if (full_tick) next_state = STOP;
`else
                next_state = STOP;
`endif
      STOP:   if (full_tick) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy_c    = (state != IDLE);
    half_tick = (cnt == CNT_HALF);
    full_tick = (cnt == CNT_FULL);
    data_smp  = (state == DATA) && full_tick;
    stop_smp  = (state == STOP) && full_tick;
    // Every bit period restarts the count, including DATA -> DATA.
    cnt_clr   = (state == IDLE) || (next_state != state) || full_tick;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      armed    <= 1'b0;
      done     <= 1'b0;
      stop_bit <= 1'b0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CW'(1);
      if (state == START)  bit_idx <= '0;
      else if (data_smp)   bit_idx <= bit_idx + BW'(1);
      if (data_smp) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      // A break keeps the line low; refuse a new start until it has idled high.
      if (stop_smp)                       armed <= 1'b0;
      else if (state == IDLE && rx_s)     armed <= 1'b1;
      done <= stop_smp;
      if (stop_smp) stop_bit <= rx_s;
    end
  end

  assign accept = valid_r && bus.ready;
  assign load   = done && (!valid_r || bus.ready);
  assign drop   = done && valid_r && !bus.ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r      <= '0;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      if (load) begin
        data_r      <= shreg;
        frame_err_r <= !stop_bit;
        valid_r     <= 1'b1;
      end else if (accept) begin
        valid_r <= 1'b0;
      end
      if (drop)        overrun_r <= 1'b1;
      else if (accept) overrun_r <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic par_bit, parity_err_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bit      <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      if (state == PARITY && full_tick) par_bit <= rx_s;
      if (load) parity_err_r <= ((^shreg) ^ par_bit) != PAR_ODD;
    end
  end

  assign bus.parity_err = parity_err_r;
`endif

  assign bus.data      = data_r;
  assign bus.valid     = valid_r;
  assign bus.frame_err = frame_err_r;
  assign bus.overrun   = overrun_r;
  assign bus.busy      = busy_c;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// tb_uart_rx_param -- randomized self-checking bench for uart_rx_param.
// Rev 1.0; honours UART_RX_PARITY_EN.
module tb_uart_rx_param;
  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 3 + H + (DB + 2) * CPB;
`else
  localparam int LAT = 3 + H + (DB + 1) * CPB;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rise_count = 0;
  int   last_rise = -1;
  logic prev_valid = 1'b0;

  uart_rx_param_if #(.DATA_BITS(DB)) bus();

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_ODD(0)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // cyc at a negedge equals the index of the posedge just taken.
  always @(negedge clk) begin
    if (bus.valid === 1'b1 && prev_valid !== 1'b1) begin
      rise_count <= rise_count + 1;
      last_rise  <= cyc;
    end
    prev_valid <= bus.valid;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  // Even parity: XOR over payload and parity bit is 0.
  function automatic logic good_par(input logic [7:0] b);
    return ^b;
  endfunction

  // Called at a negedge; t_fall is the first posedge that sees the start bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_b,
                            output int t_fall);
    t_fall = cyc + 1;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_b;
    repeat (CPB) @(negedge clk);
`endif
    rx = stop_b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [DB+3:0] v;
    rst = 1'b1; rx = 1'b1; bus.ready = 1'b0;
    repeat (3) @(negedge clk);
    v = {bus.data, bus.valid, bus.busy, bus.frame_err, bus.overrun};
    tests++;
    if (v !== '0) begin fails++; $display("FAIL reset_hold: got %h, expected 0", v); end
    rst = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      v = {bus.data, bus.valid, bus.busy, bus.frame_err, bus.overrun};
      tests++;
      if (v !== '0) begin fails++; $display("FAIL reset_idle[%0d]: got %h, expected 0", k, v); end
    end
  endtask

  task automatic test_random_frames();
    int t;
    logic [7:0] b;
    for (int n = 0; n < 5; n++) begin
      b = (n == 0) ? 8'hA5 : 8'($urandom);
      bus.ready = 1'b0;
      send_frame(b, 1'b1, good_par(b), t);
      repeat (4) @(negedge clk);
      tests++;
      if (last_rise !== t + LAT) begin fails++; $display("FAIL latency: got %0d, expected %0d", last_rise - t, LAT); end
      tests++;
      if (bus.valid !== 1'b1 || bus.data !== b) begin fails++; $display("FAIL frame_data: got v=%b d=%h, expected v=1 d=%h", bus.valid, bus.data, b); end
      tests++;
      if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL frame_ferr: got %b, expected 0", bus.frame_err); end
`ifdef UART_RX_PARITY_EN
      tests++;
      if (bus.parity_err !== 1'b0) begin fails++; $display("FAIL frame_perr: got %b, expected 0", bus.parity_err); end
`endif
      bus.ready = 1'b1;
      @(negedge clk);
      bus.ready = 1'b0;
      tests++;
      if (bus.valid !== 1'b0) begin fails++; $display("FAIL accept_clear: got valid=%b, expected 0", bus.valid); end
    end
  endtask

  task automatic test_glitch();
    int   r0;
    logic saw;
    r0 = rise_count; saw = 1'b0;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) saw = 1'b1;
    end
    tests++;
    if (saw !== 1'b1) begin fails++; $display("FAIL glitch_busy: got %b, expected 1", saw); end
    tests++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL glitch_idle: got busy=%b, expected 0", bus.busy); end
    tests++;
    if (rise_count !== r0) begin fails++; $display("FAIL glitch_valid: got %0d rises, expected 0", rise_count - r0); end
  endtask

  task automatic test_break();
    int t, r0;
    bus.ready = 1'b0;
    send_frame(8'h3C, 1'b0, good_par(8'h3C), t);
    repeat (4) @(negedge clk);
    tests++;
    if (bus.valid !== 1'b1 || bus.data !== 8'h3C || bus.frame_err !== 1'b1) begin
      fails++; $display("FAIL break_frame: got v=%b d=%h fe=%b, expected v=1 d=3c fe=1", bus.valid, bus.data, bus.frame_err);
    end
    r0 = rise_count;
    repeat (60) @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.overrun !== 1'b0 || rise_count !== r0) begin
      fails++; $display("FAIL break_hold: got busy=%b ovr=%b rises=%0d, expected 0 0 0", bus.busy, bus.overrun, rise_count - r0);
    end
    bus.ready = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h01, 1'b1, good_par(8'h01), t);
    repeat (4) @(negedge clk);
    tests++;
    if (bus.valid !== 1'b1 || bus.data !== 8'h01 || bus.frame_err !== 1'b0) begin
      fails++; $display("FAIL break_recover: got v=%b d=%h fe=%b, expected v=1 d=01 fe=0", bus.valid, bus.data, bus.frame_err);
    end
    bus.ready = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
  endtask

  task automatic test_overrun();
    int t;
    bus.ready = 1'b0;
    send_frame(8'h11, 1'b1, good_par(8'h11), t);
    send_frame(8'h22, 1'b1, good_par(8'h22), t);
    repeat (4) @(negedge clk);
    tests++;
    if (bus.valid !== 1'b1 || bus.data !== 8'h11 || bus.overrun !== 1'b1) begin
      fails++; $display("FAIL overrun_set: got v=%b d=%h ovr=%b, expected v=1 d=11 ovr=1", bus.valid, bus.data, bus.overrun);
    end
    bus.ready = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
    tests++;
    if (bus.valid !== 1'b0 || bus.overrun !== 1'b0) begin
      fails++; $display("FAIL overrun_clear: got v=%b ovr=%b, expected 0 0", bus.valid, bus.overrun);
    end
  endtask

  task automatic test_back_to_back();
    int t, t0, r0;
    logic [7:0] a, b;
    a = 8'($urandom); b = 8'($urandom);
    if (b == a) b = ~a;
    bus.ready = 1'b0;
    send_frame(a, 1'b1, good_par(a), t);
    repeat (4) @(negedge clk);
    tests++;
    if (bus.valid !== 1'b1 || bus.data !== a) begin fails++; $display("FAIL b2b_first: got v=%b d=%h, expected v=1 d=%h", bus.valid, bus.data, a); end
    r0 = rise_count;
    t0 = cyc + 1;
    fork
      send_frame(b, 1'b1, good_par(b), t);
      begin
        // Accept the pending frame in the very cycle the next one completes.
        while (cyc != t0 + LAT - 1) @(negedge clk);
        bus.ready = 1'b1;
        @(negedge clk);
        bus.ready = 1'b0;
        tests++;
        if (bus.valid !== 1'b1 || bus.data !== b || bus.overrun !== 1'b0) begin
          fails++; $display("FAIL b2b_same_cycle: got v=%b d=%h ovr=%b, expected v=1 d=%h ovr=0", bus.valid, bus.data, bus.overrun, b);
        end
      end
    join
    repeat (2) @(negedge clk);
    tests++;
    if (rise_count !== r0) begin fails++; $display("FAIL b2b_valid_gap: got %0d new rises, expected 0", rise_count - r0); end
  endtask

  task automatic test_reset_mid_frame();
    int t, t0;
    logic [DB+3:0] v;
    t0 = cyc + 1;
    fork
      send_frame(8'hFF, 1'b1, good_par(8'hFF), t);
      begin
        while (cyc != t0 + 5 * CPB + H) @(negedge clk);
        tests++;
        if (bus.busy !== 1'b1 || bus.valid !== 1'b1) begin
          fails++; $display("FAIL midrst_pre: got busy=%b v=%b, expected 1 1", bus.busy, bus.valid);
        end
        #2 rst = 1'b1;
        #1 v = {bus.data, bus.valid, bus.busy, bus.frame_err, bus.overrun};
        tests++;
        if (v !== '0) begin fails++; $display("FAIL midrst_async: got %h, expected 0", v); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    join
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    tests++;
    if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_nothing: got v=%b busy=%b, expected 0 0", bus.valid, bus.busy); end
    send_frame(8'h5A, 1'b1, good_par(8'h5A), t);
    repeat (4) @(negedge clk);
    tests++;
    if (bus.valid !== 1'b1 || bus.data !== 8'h5A || bus.frame_err !== 1'b0 || last_rise !== t + LAT) begin
      fails++; $display("FAIL midrst_next: got v=%b d=%h fe=%b lat=%0d, expected v=1 d=5a fe=0 lat=%0d", bus.valid, bus.data, bus.frame_err, last_rise - t, LAT);
    end
    bus.ready = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
  endtask

  task automatic test_stream();
    logic [7:0] exp_q[$];
    logic       snd_done;
    int         idle;
    snd_done = 1'b0; idle = 0;
    fork
      begin
        int tt;
        logic [7:0] b;
        for (int n = 0; n < 8; n++) begin
          b = 8'($urandom);
          exp_q.push_back(b);
          send_frame(b, 1'b1, good_par(b), tt);
          repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        snd_done = 1'b1;
      end
      begin
        logic r;
        logic [7:0] e;
        for (int k = 0; k < 5000 && idle < LAT + 40; k++) begin
          @(negedge clk);
          r = 1'($urandom_range(0, 1));
          if (bus.valid === 1'b1 && r) begin
            tests++;
            if (exp_q.size() == 0) begin
              fails++; $display("FAIL stream_extra: got %h, expected no frame", bus.data);
            end else begin
              e = exp_q.pop_front();
              if (bus.data !== e || bus.frame_err !== 1'b0) begin
                fails++; $display("FAIL stream_data: got d=%h fe=%b, expected d=%h fe=0", bus.data, bus.frame_err, e);
              end
            end
          end
          bus.ready = r;
          if (snd_done) idle++;
        end
      end
    join
    bus.ready = 1'b0;
    tests++;
    if (exp_q.size() != 0 || bus.overrun !== 1'b0) begin
      fails++; $display("FAIL stream_end: got %0d missing ovr=%b, expected 0 missing ovr=0", exp_q.size(), bus.overrun);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int t;
    logic [7:0] b;
    logic       pb [3];
    logic       exp_err [3];
    pb[0] = 1'b1; exp_err[0] = 1'b0;
    pb[1] = 1'b0; exp_err[1] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      b = (n < 2) ? 8'h07 : 8'($urandom);
      if (n == 2) begin pb[2] = ~good_par(b); exp_err[2] = 1'b1; end
      bus.ready = 1'b0;
      send_frame(b, 1'b1, pb[n], t);
      repeat (4) @(negedge clk);
      tests++;
      if (bus.valid !== 1'b1 || bus.data !== b || bus.parity_err !== exp_err[n] || last_rise !== t + LAT) begin
        fails++; $display("FAIL parity[%0d]: got v=%b d=%h pe=%b lat=%0d, expected v=1 d=%h pe=%b lat=%0d", n, bus.valid, bus.data, bus.parity_err, last_rise - t, b, exp_err[n], LAT);
      end
      bus.ready = 1'b1;
      @(negedge clk);
      bus.ready = 1'b0;
    end
  endtask
`endif

  initial begin
    bus.ready = 1'b0;
    test_reset();
    test_random_frames();
    test_glitch();
    test_break();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    test_stream();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised successor to the single-clock-per-bit UART receiver.
- Oversamples the line at CLKS_PER_BIT clocks per bit, samples mid-bit, and supports configurable data width.
- Checks the stop bit and delivers each byte over a valid/ready handshake, with framing and overrun flags.
- Sits between the board RX pin and the bring-up command/loader logic.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit; even, >= 4.
- DATA_BITS, 8: payload bits per frame, 5..9, LSB first.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; only meaningful with UART_RX_PARITY_EN.

Ports:
- clk  in  1: system clock.
- rst  in  1: asynchronous, active-high reset.
- rx  in  1: serial line, asynchronous to clk, idle high.
- data  out  DATA_BITS: received payload; stable while valid=1.
- valid  out  1: payload available.
- ready  in  1: consumer accepts when valid&&ready.
- frame_err  out  1: stop bit sampled 0 for the frame currently in data.
- overrun  out  1: sticky; a frame completed while valid=1 and was dropped.
- busy  out  1: state != IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, synchroniser flops=1, counters=0.
  - data=0, valid=0, frame_err=0, overrun=0, busy=0.
  - Reset mid-frame aborts the frame; nothing is delivered.
- rx passes through a 2-FF synchroniser (output rx_s, reset value 1). Cycle counter cnt; H = CLKS_PER_BIT/2.
- IDLE:
  - Armed only after rx_s=1 has been seen; the armed flag is cleared on entry from STOP.
  - When armed and rx_s=0: next state START, cnt=0.
- START: at cnt=H-1, sample rx_s.
  - Sample 1: glitch, return to IDLE.
  - Sample 0: go to DATA, cnt=0, bit index=0.
- DATA: at cnt=CLKS_PER_BIT-1, sample rx_s and shift right into the shift register (new bit enters the MSB, so the LSB ends up in bit 0), cnt=0. After DATA_BITS samples, go to STOP (or PARITY when enabled).
- STOP: at cnt=CLKS_PER_BIT-1, sample rx_s, then go to IDLE, disarmed.
- Completion (stop sample), registered on the next cycle:
  - If valid=0, or valid&&ready in the same cycle: data<=shift register, frame_err<=~stop_sample, valid<=1.
  - Otherwise the frame is discarded: data and frame_err are unchanged, overrun<=1.
- Handshake:
  - valid&&ready with no completion that cycle: valid<=0.
  - overrun clears on the cycle of any accepted handshake, unless a new drop occurs in that same cycle (drop wins).
- Latency: falling edge on pin at cycle 0 → valid=1 at cycle 3+H+(DATA_BITS+1)*CLKS_PER_BIT. With the defaults this is cycle 155.
- A stop bit of 0 (break) yields valid=1 with frame_err=1. No new start is detected until rx_s has returned to 1.
- Counters are sized $clog2(CLKS_PER_BIT) and $clog2(DATA_BITS+1) bits. No wrap occurs inside a bit period.

Optional Feature:
- UART_RX_PARITY_EN defined:
  - A PARITY state follows DATA and samples one extra bit at cnt=CLKS_PER_BIT-1.
  - Output port parity_err is added; it is registered alongside data on completion.
  - parity_err=1 when the XOR of data bits and the parity bit is not PARITY_ODD.
  - Latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state, no parity_err port, frame = start + DATA_BITS + stop.

Decomposition:
- Package uart_pkg holds:
  - State encodings: IDLE, START, DATA, PARITY, STOP.
  - Helper constant function for counter width.
- Sub-module uart_sync2: parametrised-reset-value 2-FF synchroniser on clk/rst. It is reused by a future TX/loopback block.

Test Plan:
1. Reset and idle: rst pulse with rx=1 held for 100 cycles → data=0, valid=0, busy=0, frame_err=0, overrun=0 throughout.
2. Frame 0xA5 with defaults, ready=0: valid rises exactly at cycle 155 after the pin falling edge, data=0xA5, frame_err=0. ready=1 for one cycle → valid=0 the next cycle.
3. Glitch: rx=0 for 4 cycles then 1 → busy asserts, returns to IDLE after the mid-start sample, valid never asserts.
4. Break: frame 0x3C with stop bit 0 → valid=1, data=0x3C, frame_err=1. Hold rx=0 a further 64 cycles → no second frame, busy=0. Then rx=1 and frame 0x01 → data=0x01, frame_err=0.
5. Overrun and back-to-back:
   - Frames 0x11 then 0x22 back-to-back with ready=0 → data=0x11, overrun=1.
   - ready=1 → accepted, overrun=0, valid=0.
   - Completion and accept in the same cycle → new data loaded, valid stays 1, overrun=0.
6. Reset mid-frame, and parity (with UART_RX_PARITY_EN, PARITY_ODD=0):
   - rst asserted at bit 4 of frame 0xFF → outputs all 0 immediately; the following clean frame 0x5A is received correctly.
   - Parity: 0x07 with parity bit 1 → parity_err=0; with parity bit 0 → parity_err=1.
